// File: rtl/serial_comparator.sv
// serial_comparator: multi-cycle WIDTH-bit magnitude comparator, one 4-bit
// slice per clock (MSB slice first) using greater/equal/less cascade semantics.
// Optional feature macro: EARLY_EXIT_EN (finish on the first differing slice).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, accepted only in IDLE or DONE
//   a, b                WIDTH-bit operands, latched on the accepting edge
//   g_in, e_in, l_in    cascade inputs, used when all slices are equal
//   busy                high while comparing
//   done                one-cycle pulse when the result registers update
//   g_out, e_out, l_out registered A>B / A==B / A<B result
module serial_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             g_in,
    input  logic             e_in,
    input  logic             l_in,
    output logic             busy,
    output logic             done,
    output logic             g_out,
    output logic             e_out,
    output logic             l_out
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    localparam logic [2:0] ACC_GT = 3'b100;
    localparam logic [2:0] ACC_EQ = 3'b010;
    localparam logic [2:0] ACC_LT = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       cas_q, cas_d;
    logic [2:0]       acc_q, acc_d;
    logic [2:0]       res_q, res_d;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [2:0]       acc_upd;
    logic             last;

    // Operands are shifted left each RUN cycle, so the slice under
    // comparison is always the top nibble.
    assign slice_a = a_q[WIDTH-1 -: 4];
    assign slice_b = b_q[WIDTH-1 -: 4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cas_d   = cas_q;
        acc_d   = acc_q;
        res_d   = res_q;

        // Once a higher slice has decided the result, lower slices are moot.
        if (acc_q[2] | acc_q[0]) begin
            acc_upd = acc_q;
        end else if (slice_a > slice_b) begin
            acc_upd = ACC_GT;
        end else if (slice_a < slice_b) begin
            acc_upd = ACC_LT;
        end else begin
            acc_upd = ACC_EQ;
        end

        last = (cnt_q == '0);
`ifdef EARLY_EXIT_EN
        last = last | acc_upd[2] | acc_upd[0];
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_LAST;
                    a_d     = a;
                    b_d     = b;
                    cas_d   = {g_in, e_in, l_in};
                    acc_d   = ACC_EQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_upd;
                a_d   = a_q << 4;
                b_d   = b_q << 4;
                if (last) begin
                    state_d = S_DONE;
                    // All slices equal: pass the cascade inputs through as-is.
                    res_d   = (acc_upd == ACC_EQ) ? cas_q : acc_upd;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cas_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cas_q   <= cas_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign g_out = res_q[2];
    assign e_out = res_q[1];
    assign l_out = res_q[0];

endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: directed bench for serial_comparator with a
// result scoreboard and a cycle-level timing model.
module tb_serial_comparator;

    localparam int W  = 16;
    localparam int NS = W / 4;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         g_in  = 1'b0;
    logic         e_in  = 1'b0;
    logic         l_in  = 1'b0;
    logic         busy;
    logic         done;
    logic         g_out;
    logic         e_out;
    logic         l_out;

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .g_in  (g_in),
        .e_in  (e_in),
        .l_in  (l_in),
        .busy  (busy),
        .done  (done),
        .g_out (g_out),
        .e_out (e_out),
        .l_out (l_out)
    );

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;
    logic [2:0] exp_res  = 3'b000;
    int         left     = 0;
    logic [2:0] sb[$];

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    function automatic int lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int n = NS;
        for (int i = NS - 1; i >= 0; i--) begin
            if (EE && n == NS && x[4*i +: 4] != y[4*i +: 4]) n = NS - i;
        end
        return n;
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [2:0] cas);
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return cas;
    endfunction

    // Advance the model across one rising edge using the current inputs,
    // then check the DUT at the following falling edge.
    task automatic cyc();
        if (!rst_n) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_res  = 3'b000;
            left     = 0;
        end else if (exp_busy) begin
            left--;
            exp_done = 1'b0;
            if (left == 0) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
            end
        end else if (start) begin
            exp_busy = 1'b1;
            exp_done = 1'b0;
            left     = lat(a, b);
            sb.push_back(ref_cmp(a, b, {g_in, e_in, l_in}));
        end else begin
            exp_done = 1'b0;
        end
        @(negedge clk);
        chk("busy", {2'b00, busy}, {2'b00, exp_busy});
        chk("done", {2'b00, done}, {2'b00, exp_done});
        if (exp_done) begin
            chk("sb_nonempty", {2'b00, sb.size() != 0}, 3'b001);
            if (sb.size() != 0) exp_res = sb.pop_front();
        end
        chk("result", {g_out, e_out, l_out}, exp_res);
    endtask

    task automatic scramble();
        a = W'($urandom);
        b = W'($urandom);
        {g_in, e_in, l_in} = 3'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * NS + 4 && (exp_busy || exp_done); i++) cyc();
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2:0] cas);
        a = x;
        b = y;
        {g_in, e_in, l_in} = cas;
        start = 1'b1;
        cyc();
        start = 1'b0;
        scramble();
        drain();
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_res  = 3'b000;
        left     = 0;
        sb.delete();
        chk("rst_busy", {2'b00, busy}, 3'b000);
        chk("rst_done", {2'b00, done}, 3'b000);
        chk("rst_result", {g_out, e_out, l_out}, 3'b000);
    endtask

    initial begin
        // Reset held for two cycles, then released with start low.
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();

        launch(16'h8000, 16'h0001, 3'b010);
        launch(16'h0000, 16'h0001, 3'b010);
        launch(16'h0505, 16'h0505, 3'b010);
        launch(16'h0505, 16'h0505, 3'b100);
        launch(16'hFFFF, 16'hFFFF, 3'b111);
        launch(16'h1234, 16'h1243, 3'b000);
        launch(16'hFFFF, 16'h0000, 3'b001);
        launch(16'h0F00, 16'h0E99, 3'b010);
        cyc();

        // start held high with operands changing every cycle.
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            b = (i % 3 == 0) ? a : W'($urandom);
            {g_in, e_in, l_in} = 3'b010;
            cyc();
        end
        start = 1'b0;
        scramble();
        drain();
        cyc();

        // Abort during the second slice.
        a = 16'h1234;
        b = 16'h1234;
        {g_in, e_in, l_in} = 3'b010;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        reset_now();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        launch(16'h4321, 16'h4322, 3'b010);
        cyc();

        chk("sb_empty", {2'b00, sb.size() == 0}, 3'b001);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
